// File: rtl/mult_div_pkg.sv
// Shared definitions for the multiplier/divider pair: state encoding,
// default operand width and the iteration-counter width helper.
package mult_div_pkg;

  localparam int N_DEFAULT = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Counter must reach 2N-1, one step per quotient bit.
  function automatic int cnt_width(input int n);
    return $clog2(2 * n);
  endfunction

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor, and restore on borrow.
module div_restore_step #(
  parameter int N = 4
) (
  input  logic [N:0]   r_in,
  input  logic         q_msb,
  input  logic [N-1:0] divisor,
  output logic [N:0]   r_out,
  output logic         q_bit
);

  logic [N+1:0] shifted;
  logic [N+1:0] trial;

  // The partial remainder stays below the divisor, so the top of the shifted
  // value is always zero; the borrow lands in the MSB of the trial difference.
  assign shifted = {r_in, q_msb};
  assign trial   = shifted - {2'b00, divisor};
  assign q_bit   = ~trial[N+1];
  assign r_out   = q_bit ? trial[N:0] : shifted[N:0];

endmodule

// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider: 2N-bit dividend by N-bit divisor,
// one quotient bit per clock, divide-by-zero reported in a single cycle.
module seq_restoring_divider
  import mult_div_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] quotient,
  output logic [N-1:0]   remainder,
  output logic           div_by_zero
);

  localparam int CW = cnt_width(N);

  logic [1:0]     state_q,     state_d;
  logic [CW-1:0]  cnt_q,       cnt_d;
  logic [2*N-1:0] q_q,         q_d;
  logic [N:0]     r_q,         r_d;
  logic [N-1:0]   divisor_q,   divisor_d;
  logic [2*N-1:0] quotient_q,  quotient_d;
  logic [N-1:0]   remainder_q, remainder_d;
  logic           dbz_q,       dbz_d;

  logic [N:0]     step_r;
  logic           step_qbit;

  div_restore_step #(.N(N)) u_step (
    .r_in    (r_q),
    .q_msb   (q_q[2*N-1]),
    .divisor (divisor_q),
    .r_out   (step_r),
    .q_bit   (step_qbit)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values computed by the combinational blocks.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      q_q         <= '0;
      r_q         <= '0;
      divisor_q   <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      q_q         <= q_d;
      r_q         <= r_d;
      divisor_q   <= divisor_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  // NOTE: every always_comb output gets a default first so no path
  // through the case statement can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = (divisor == '0) ? S_DONE : S_RUN;
      S_RUN:   if (cnt_q == '0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    q_d         = q_q;
    r_d         = r_q;
    divisor_d   = divisor_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          r_d = '0;
          if (divisor == '0) begin
            q_d         = '1;
            quotient_d  = '1;
            remainder_d = '0;
            dbz_d       = 1'b1;
          end else begin
            q_d       = dividend;
            divisor_d = divisor;
            cnt_d     = CW'(2 * N - 1);
          end
        end
      end
      S_RUN: begin
        q_d   = {q_q[2*N-2:0], step_qbit};
        r_d   = step_r;
        cnt_d = cnt_q - 1'b1;
        // Result registers load on the last step so they are valid with done.
        if (cnt_q == '0) begin
          quotient_d  = {q_q[2*N-2:0], step_qbit};
          remainder_d = step_r[N-1:0];
          dbz_d       = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy        = (state_q != S_IDLE);
    done        = (state_q == S_DONE);
    quotient    = quotient_q;
    remainder   = remainder_q;
    div_by_zero = dbz_q;
  end

endmodule
